// File: rtl/tff_bank_counter.sv
// WIDTH-bit register of T flip-flop cells with masked toggle, up/down count,
// parallel load, terminal-count detect, a wrap pulse and a sticky overflow flag.
module tff_bank_counter #(
    parameter int               WIDTH     = 8,
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] t_mask_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             clr_ovf_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] qbar_o,
    output logic             tc_o,
    output logic             wrap_o,
    output logic             ovf_o
);

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_UP     = 2'b10;
    localparam logic [1:0] MODE_DOWN   = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] t_vec;
    logic             all_ones;
    logic             all_zero;
    logic             edge_event;

    // T inputs for counting: a bit toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        up_t    = '0;
        dn_t    = '0;
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_t[i] = up_t[i-1] & q_q[i-1];
            dn_t[i] = dn_t[i-1] & ~q_q[i-1];
        end
    end

    assign all_ones = up_t[WIDTH-1] & q_q[WIDTH-1];
    assign all_zero = dn_t[WIDTH-1] & ~q_q[WIDTH-1];

    always_comb begin
        t_vec      = '0;
        edge_event = 1'b0;
        if (en_i) begin
            case (mode_i)
                MODE_TOGGLE: t_vec = t_mask_i;
                MODE_UP: begin
                    edge_event = all_ones;
                    t_vec      = (all_ones && SATURATE) ? '0 : up_t;
                end
                MODE_DOWN: begin
                    edge_event = all_zero;
                    t_vec      = (all_zero && SATURATE) ? '0 : dn_t;
                end
                default: t_vec = '0;
            endcase
        end
    end

    always_comb begin
        q_d    = q_q ^ t_vec;
        wrap_d = edge_event;
        ovf_d  = edge_event | (ovf_q & ~clr_ovf_i);
        if (load_i) begin
            q_d    = load_val_i;
            wrap_d = 1'b0;
            ovf_d  = ovf_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            q_q    <= RESET_VAL;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign q_o    = q_q;
    assign qbar_o = ~q_q;
    assign wrap_o = wrap_q;
    assign ovf_o  = ovf_q;
    assign tc_o   = ((mode_i == MODE_UP) && all_ones) || ((mode_i == MODE_DOWN) && all_zero);

endmodule
